// File: rtl/pack_pkg.sv
// -----------------------------------------------------------------------------
// pack_pkg
// Shared constants and types for the 2-bit wire-packing sequencer.
//   LANES      operand words collected per frame
//   WORD_W     sorted / packed word width (LANES*SLICE_W == WORD_W)
//   SLICE_W    bits per slice
//   NUM_SLICES number of slices in one word
//   IDX_W      width of a slice index
//   LANE_W     width of a lane index
//   pack_state_t  controller state (LOAD collects lanes, DRAIN emits slices)
//   word_t        one operand / packed word
// -----------------------------------------------------------------------------
package pack_pkg;

  localparam int LANES      = 16;
  localparam int WORD_W     = 32;
  localparam int SLICE_W    = 2;
  localparam int NUM_SLICES = WORD_W / SLICE_W;
  localparam int IDX_W      = $clog2(NUM_SLICES);
  localparam int LANE_W     = $clog2(LANES);

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } pack_state_t;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pack_slice_mux.sv
// -----------------------------------------------------------------------------
// pack_slice_mux
// Combinational bit-slice packer. For the selected slice k, lane j of the
// output (bits [SLICE_W*j +: SLICE_W]) is bits [SLICE_W*k +: SLICE_W] of
// operand word j, so lane 0 lands in the LSBs.
// Ports:
//   lanes_i    in   LANES x word_t   operand words of the frame
//   slice_idx  in   IDX_W            slice to extract
//   packed_o   out  word_t           packed slice word
// -----------------------------------------------------------------------------
module pack_slice_mux
  import pack_pkg::*;
(
  input  word_t            lanes_i [LANES],
  input  logic [IDX_W-1:0] slice_idx,
  output word_t            packed_o
);

  // Decode the slice index so every part-select uses constant bounds.
  always_comb begin
    packed_o = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (slice_idx == IDX_W'(k)) begin
        for (int j = 0; j < LANES; j++) begin
          packed_o[j*SLICE_W +: SLICE_W] = lanes_i[j][k*SLICE_W +: SLICE_W];
        end
      end
    end
  end

endmodule

// File: rtl/pack_stream_ctrl.sv
// -----------------------------------------------------------------------------
// pack_stream_ctrl
// Sequencer between the sorter and the BitBlade PE array. Collects LANES
// sorted operand words (one per accepted beat), then streams the packed
// bit-slice words, one per output handshake.
// Optional feature macro: PACK_FRAME_CNT_EN adds a 16-bit completed-frame
// counter on output frame_cnt (wraps at 16'hFFFF).
// Ports:
//   clk            in   1       clock, rising edge
//   reset          in   1       synchronous, active-high
//   cfg_slices_m1  in   IDX_W   slices to emit minus 1, latched on lane 0
//   in_valid       in   1       sorted word valid
//   in_ready       out  1       controller can accept a word (LOAD only)
//   in_data        in   WORD_W  sorted operand word, lane = arrival order
//   out_valid      out  1       packed word valid
//   out_ready      in   1       consumer accepts
//   out_data       out  WORD_W  packed slice word
//   out_slice_idx  out  IDX_W   slice index of out_data
//   out_last       out  1       out_data is the frame's final slice
//   busy           out  1       partial load or drain in progress
//   frame_done     out  1       pulse the cycle after the final handshake
//   frame_cnt      out  16      completed frames (PACK_FRAME_CNT_EN only)
// -----------------------------------------------------------------------------
module pack_stream_ctrl
  import pack_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] cfg_slices_m1,
  input  logic             in_valid,
  output logic             in_ready,
  input  word_t            in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t            out_data,
  output logic [IDX_W-1:0] out_slice_idx,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
`ifdef PACK_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  pack_state_t       state_q, state_d;
  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [IDX_W-1:0]  slice_cnt_q, slice_cnt_d;
  logic [IDX_W-1:0]  slices_m1_q, slices_m1_d;
  logic              out_valid_q, out_valid_d;
  word_t             out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  word_t             lane_buf_q [LANES];
  word_t             lane_buf_d [LANES];

  logic              in_fire;
  logic              out_fire;
  logic              last_lane;
  logic [IDX_W-1:0]  mux_sel;
  word_t             mux_word;

  assign in_ready  = (state_q == LOAD);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign last_lane = (lane_cnt_q == LANE_W'(LANES - 1));

  // Lane buffer update and mux select. The mux sees the buffer including the
  // word arriving this cycle so slice 0 is ready on the LOAD->DRAIN edge.
  always_comb begin
    lane_buf_d = lane_buf_q;
    if (in_fire) begin
      lane_buf_d[lane_cnt_q] = in_data;
    end
    mux_sel = (state_q == LOAD) ? '0 : (slice_cnt_q + IDX_W'(1));
  end

  pack_slice_mux u_slice_mux (
    .lanes_i   (lane_buf_d),
    .slice_idx (mux_sel),
    .packed_o  (mux_word)
  );

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    slice_cnt_d  = slice_cnt_q;
    slices_m1_d  = slices_m1_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_fire) begin
          if (lane_cnt_q == '0) begin
            slices_m1_d = cfg_slices_m1;
          end
          if (last_lane) begin
            lane_cnt_d  = '0;
            slice_cnt_d = '0;
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            out_data_d  = mux_word;
            out_idx_d   = '0;
            out_last_d  = (slices_m1_d == '0);
          end else begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (slice_cnt_q == slices_m1_q) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = LOAD;
          end else begin
            slice_cnt_d = slice_cnt_q + IDX_W'(1);
            out_data_d  = mux_word;
            out_idx_d   = slice_cnt_q + IDX_W'(1);
            out_last_d  = ((slice_cnt_q + IDX_W'(1)) == slices_m1_q);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      lane_cnt_q   <= '0;
      slice_cnt_q  <= '0;
      slices_m1_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      slice_cnt_q  <= slice_cnt_d;
      slices_m1_q  <= slices_m1_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Operand storage carries no reset; stale lanes are always overwritten
  // before they can be emitted.
  always_ff @(posedge clk) begin
    lane_buf_q <= lane_buf_d;
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_slice_idx = out_idx_q;
  assign out_last      = out_last_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q == DRAIN) | (lane_cnt_q != '0);

`ifdef PACK_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts on the same edge that raises frame_done; wraps naturally.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_done_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pack_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pack_stream_ctrl
// Directed testbench for pack_stream_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Expected values are hand-computed
// constants per scenario.
// -----------------------------------------------------------------------------
module tb_pack_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cfg_slices_m1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_slice_idx;
  logic        out_last;
  logic        busy;
  logic        frame_done;
`ifdef PACK_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] frame_w [16];

  always #5 clk = ~clk;

  pack_stream_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_slices_m1 (cfg_slices_m1),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_slice_idx (out_slice_idx),
    .out_last      (out_last),
    .busy          (busy),
    .frame_done    (frame_done)
`ifdef PACK_FRAME_CNT_EN
    ,
    .frame_cnt     (frame_cnt)
`endif
  );

  // Called at a falling edge; returns at the falling edge after the last beat.
  // cfg_slices_m1 is only meaningful on lane 0; later beats present its
  // complement, which the controller must ignore.
  task automatic load_frame(input logic [3:0] m1);
    int wait_cyc;
    for (int i = 0; i < 16; i++) begin
      wait_cyc = 0;
      while (in_ready !== 1'b1 && wait_cyc < 50) begin
        @(posedge clk);
        @(negedge clk);
        wait_cyc++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_in_ready lane=%0d got=%b exp=1", i, in_ready);
      end
      in_valid      = 1'b1;
      in_data       = frame_w[i];
      cfg_slices_m1 = (i == 0) ? m1 : ~m1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, out_valid, out_last, busy, frame_done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=10000",
               {in_ready, out_valid, out_last, busy, frame_done});
    end
    checks++;
    if ({out_data, out_slice_idx} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d exp=0/0", out_data, out_slice_idx);
    end
  endtask

  task automatic test_single_lane_stream();
    for (int j = 0; j < 16; j++) frame_w[j] = 32'h0;
    frame_w[0] = 32'hFFFF_FFFF;
    load_frame(4'd15);
    out_ready = 1'b1;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL drain_busy_ready got=%b exp=10", {busy, in_ready});
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({out_valid, out_data, out_slice_idx, out_last, frame_done} !==
          {1'b1, 32'h0000_0003, 4'(k), (k == 15), 1'b0}) begin
        failures++;
        $display("FAIL t1_beat k=%0d got v=%b d=%h i=%0d l=%b fd=%b exp v=1 d=00000003 i=%0d l=%b fd=0",
                 k, out_valid, out_data, out_slice_idx, out_last, frame_done, k, (k == 15));
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if ({frame_done, out_valid, in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL t1_done got=%b exp=101", {frame_done, out_valid, in_ready});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({frame_done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL t1_pulse_end got=%b exp=00", {frame_done, busy});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_one_slice();
    for (int j = 0; j < 16; j++) frame_w[j] = 32'h0000_0002;
    load_frame(4'd0);
    out_ready = 1'b1;
    checks++;
    if ({out_valid, out_data, out_slice_idx, out_last} !== {1'b1, 32'hAAAA_AAAA, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL t2_beat got v=%b d=%h i=%0d l=%b exp v=1 d=aaaaaaaa i=0 l=1",
               out_valid, out_data, out_slice_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({frame_done, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL t2_done got=%b exp=10", {frame_done, out_valid});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int j = 0; j < 16; j++) frame_w[j] = 32'h1 << (2 * j);
    load_frame(4'd15);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({out_valid, out_data, out_slice_idx, out_last} !==
          {1'b1, 32'h1 << (2 * k), 4'(k), (k == 15)}) begin
        failures++;
        $display("FAIL t3_beat k=%0d got v=%b d=%h i=%0d l=%b exp v=1 d=%h i=%0d",
                 k, out_valid, out_data, out_slice_idx, out_last, 32'h1 << (2 * k), k);
      end
      if (k == 3) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          @(negedge clk);
          checks++;
          if ({out_valid, out_data, out_slice_idx, out_last} !== {1'b1, 32'h0000_0040, 4'd3, 1'b0}) begin
            failures++;
            $display("FAIL t3_stall got v=%b d=%h i=%0d l=%b exp v=1 d=00000040 i=3 l=0",
                     out_valid, out_data, out_slice_idx, out_last);
          end
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if ({frame_done, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL t3_done got=%b exp=10", {frame_done, out_valid});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_drain_ignores_input();
    for (int j = 0; j < 16; j++) frame_w[j] = 32'h0;
    frame_w[0] = 32'h0000_0001;
    load_frame(4'd1);
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    repeat (2) begin
      checks++;
      if ({in_ready, busy, out_valid, out_slice_idx} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
        failures++;
        $display("FAIL t4_hold got r=%b b=%b v=%b i=%0d exp r=0 b=1 v=1 i=0",
                 in_ready, busy, out_valid, out_slice_idx);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if ({out_valid, out_data, out_slice_idx, out_last} !== {1'b1, 32'h1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL t4_a0 got d=%h i=%0d l=%b exp d=00000001 i=0 l=0", out_data, out_slice_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_slice_idx, out_last} !== {1'b1, 32'h0, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL t4_a1 got d=%h i=%0d l=%b exp d=00000000 i=1 l=1", out_data, out_slice_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({frame_done, in_ready, out_valid} !== 3'b110) begin
      failures++;
      $display("FAIL t4_done got=%b exp=110", {frame_done, in_ready, out_valid});
    end
    // Next frame: lane 0 is the first word presented after frame_done.
    for (int j = 0; j < 16; j++) frame_w[j] = 32'h0;
    frame_w[0] = 32'h0000_000C;
    load_frame(4'd1);
    checks++;
    if ({out_valid, out_data, out_slice_idx} !== {1'b1, 32'h0, 4'd0}) begin
      failures++;
      $display("FAIL t4_b0 got v=%b d=%h i=%0d exp v=1 d=00000000 i=0", out_valid, out_data, out_slice_idx);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_slice_idx, out_last} !== {1'b1, 32'h3, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL t4_b1 got d=%h i=%0d l=%b exp d=00000003 i=1 l=1", out_data, out_slice_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      in_valid      = 1'b1;
      in_data       = 32'hFFFF_FFFF;
      cfg_slices_m1 = 4'd15;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b110) begin
      failures++;
      $display("FAIL t5_partial got=%b exp=110", {busy, in_ready, out_valid});
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      failures++;
      $display("FAIL t5_after_reset got=%b exp=100", {in_ready, busy, out_valid});
    end
    for (int j = 0; j < 16; j++) frame_w[j] = 32'h1 << (2 * j);
    load_frame(4'd1);
    out_ready = 1'b1;
    checks++;
    if ({out_valid, out_data, out_slice_idx, out_last} !== {1'b1, 32'h1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL t5_s0 got v=%b d=%h i=%0d l=%b exp v=1 d=00000001 i=0 l=0",
               out_valid, out_data, out_slice_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_slice_idx, out_last} !== {1'b1, 32'h4, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL t5_s1 got v=%b d=%h i=%0d l=%b exp v=1 d=00000004 i=1 l=1",
               out_valid, out_data, out_slice_idx, out_last);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({frame_done, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL t5_done got=%b exp=10", {frame_done, out_valid});
    end
    out_ready = 1'b0;
  endtask

`ifdef PACK_FRAME_CNT_EN
  task automatic test_frame_cnt();
    do_reset();
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL fc_reset got=%0d exp=0", frame_cnt);
    end
    for (int j = 0; j < 16; j++) frame_w[j] = 32'h0;
    repeat (3) begin
      load_frame(4'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
    checks++;
    if (frame_cnt !== 16'd3) begin
      failures++;
      $display("FAIL fc_three got=%0d exp=3", frame_cnt);
    end
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_cnt_q;
    load_frame(4'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL fc_wrap got=%h exp=0000", frame_cnt);
    end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_data       = 32'h0;
    cfg_slices_m1 = 4'd0;
    out_ready     = 1'b0;
    test_reset();
    test_single_lane_stream();
    test_one_slice();
    test_backpressure();
    test_drain_ignores_input();
    test_reset_mid_frame();
`ifdef PACK_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
